mem_stage_access_unit: RTL and testbench
========================================

Name: mem_stage_access_unit

Overview:
MEM-stage consumer of the EX/MEM pipeline register. It takes the registered control signals (load, rf_le, E, size, rw_dm), the ALU address and the store data. It runs one req/ack transaction per access on the data-memory bus and stalls the pipeline while it waits. It aligns and extends load data and holds the MEM/WB pipeline register that feeds write-back.

Parameters:
TIMEOUT, 16, max cycles in WAIT without mem_ack before the access is aborted (bus error).
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  input  1  pipeline clock, rising edge.
R  input  1  synchronous active-high reset.
load_mem  input  1  destination takes memory data instead of the ALU result.
rf_le_mem  input  1  register-file write enable for this instruction.
E_mem  input  1  memory access enable.
size_mem  input  2  00 byte, 01 halfword, 10 word, 11 word.
rw_dm_mem  input  1  1 write (store), 0 read (load).
se_mem  input  1  sign-extend loaded byte/halfword (1) or zero-extend (0).
alu_out_mem  input  32  effective address / ALU result.
st_data_mem  input  32  store source register value.
rd_mem  input  5  destination register.
mem_req  output  1  bus request.
mem_we  output  1  bus write strobe.
mem_addr  output  32  word-aligned address ({alu_out_mem[31:2],2'b00}).
mem_be  output  4  byte enables, bit3 = bits 31:24.
mem_wdata  output  32  lane-replicated store data.
mem_rdata  input  32  read word.
mem_ack  input  1  transaction complete.
stall_mem  output  1  freeze PC, IF/ID, ID/EX and EX/MEM.
trap_misalign  output  1  one-cycle misaligned-access pulse.
bus_err  output  1  one-cycle timeout pulse.
wb_data  output  32  MEM/WB data.
rf_le_wb  output  1  MEM/WB write enable.
rd_wb  output  5  MEM/WB destination.

Behaviour:
- Big-endian lanes. Byte offset 0 maps to bits 31:24. Byte be = 1000>>addr[1:0]. Halfword be = 1100 or 0011 by addr[1]. Word be = 1111.
- Store data is replicated across lanes: byte {4{st[7:0]}}, halfword {2{st[15:0]}}, word st.
- Misaligned accesses: halfword with addr[0]=1; word/11 with addr[1:0]!=0.
- start = E_mem & ~misaligned, evaluated only in IDLE.
- FSM has three states: IDLE, WAIT, DONE.
- IDLE:
  - On start: go to WAIT; mem_req/mem_we/mem_addr/mem_be/mem_wdata are registered on that edge; counter cleared.
  - On misaligned E_mem: trap_misalign=1 for that cycle; no request; stay in IDLE.
- WAIT:
  - Bus outputs are held stable.
  - On mem_ack: capture mem_rdata; go to DONE; mem_req drops on that edge.
  - If counter reaches TIMEOUT-1 without ack: bus_err=1 for one cycle; drop mem_req; go to DONE with the abort flag set.
- DONE: one cycle; then go to IDLE.
- stall_mem = (IDLE & start) | WAIT. It is low in DONE, so EX/MEM advances at the end of DONE. An aligned access therefore costs at least 3 cycles (IDLE, WAIT with ack, DONE). DONE never starts a new request.
- mem_ack is ignored outside WAIT.
- Load extraction from the captured word:
  - Byte lane selected by addr[1:0]; halfword by addr[1]; word passes through.
  - Extended to 32 bits per se_mem.
- MEM/WB register (updates every edge):
  - stall_mem=1: rf_le_wb<=0 (bubble); wb_data and rd_wb hold.
  - Otherwise: rd_wb<=rd_mem and rf_le_wb<=rf_le_mem.
  - wb_data<=extracted load data if load_mem else alu_out_mem.
- Fault cases: on a misaligned cycle or an aborted DONE, rf_le_wb<=0 (trap/abort suppresses write-back).
- Stores never write back data from memory; rf_le_wb follows rf_le_mem.
- Reset (R=1 at an edge) returns to IDLE and clears all registered outputs to 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_data, rf_le_wb, rd_wb, counter.
- Reset mid-WAIT drops mem_req at that edge. A later ack is ignored.
- Combinational outputs (stall_mem, trap_misalign, bus_err) are 0 during reset.

Test Plan:
1. Aligned word load: addr 0x100, size 10, load 1, rd 5, ack two cycles after req, mem_rdata 0xDEADBEEF -> mem_be 1111; stall high 3 cycles; rf_le_wb=1, rd_wb=5, wb_data 0xDEADBEEF after DONE.
2. Signed byte load: addr 0x103, size 00, se 1, rdata 0x123456F0 -> mem_be 0001; wb_data 0xFFFFFFF0. Same with se 0 -> 0x000000F0.
3. Halfword store: addr 0x202, st_data 0x0000ABCD -> mem_we=1, mem_be 0011, mem_wdata 0xABCDABCD, mem_addr 0x200.
4. Misaligned word load at addr 0x101 -> trap_misalign one cycle; mem_req stays 0; stall_mem 0; rf_le_wb 0.
5. Timeout: TIMEOUT=16, ack never asserted -> bus_err on the 16th WAIT cycle; mem_req drops; rf_le_wb 0; FSM back in IDLE two cycles later.
6. Reset in WAIT, then ack one cycle later -> mem_req 0 after the reset edge; ack ignored; all outputs 0; next access starts cleanly.

Source files
------------

// File: rtl/mem_stage_access_unit.sv
// MEM-stage data-memory access unit: one req/ack bus transaction per access,
// big-endian lane steering, load extraction and the MEM/WB pipeline register.
module mem_stage_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        R,
  input  logic        load_mem,
  input  logic        rf_le_mem,
  input  logic        E_mem,
  input  logic [1:0]  size_mem,
  input  logic        rw_dm_mem,
  input  logic        se_mem,
  input  logic [31:0] alu_out_mem,
  input  logic [31:0] st_data_mem,
  input  logic [4:0]  rd_mem,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_mem,
  output logic        trap_misalign,
  output logic        bus_err,
  output logic [31:0] wb_data,
  output logic        rf_le_wb,
  output logic [4:0]  rd_wb
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_abort;
  logic [31:0]      r_rdata;

  logic        w_misaligned;
  logic        w_start;
  logic        w_timeout;
  logic        w_fault;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  always_comb begin
    case (size_mem)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = alu_out_mem[0];
      default: w_misaligned = |alu_out_mem[1:0];
    endcase
  end

  assign w_start   = E_mem & ~w_misaligned;
  assign w_timeout = (r_state == S_WAIT) & ~mem_ack & (r_cnt == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (R) r_state <= S_IDLE;
    else   r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_WAIT;
      S_WAIT:  if (mem_ack || w_timeout) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Combinational outputs are forced low while reset is asserted
  always_comb begin
    stall_mem     = ~R & (((r_state == S_IDLE) & w_start) | (r_state == S_WAIT));
    trap_misalign = ~R & (r_state == S_IDLE) & E_mem & w_misaligned;
    bus_err       = ~R & w_timeout;
  end

  // Byte offset 0 is the most significant lane
  always_comb begin
    case (size_mem)
      2'b00: begin
        w_be    = 4'b1000 >> alu_out_mem[1:0];
        w_wdata = {4{st_data_mem[7:0]}};
      end
      2'b01: begin
        w_be    = alu_out_mem[1] ? 4'b0011 : 4'b1100;
        w_wdata = {2{st_data_mem[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = st_data_mem;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (R) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      r_cnt     <= '0;
      r_abort   <= 1'b0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            mem_req   <= 1'b1;
            mem_we    <= rw_dm_mem;
            mem_addr  <= {alu_out_mem[31:2], 2'b00};
            mem_be    <= w_be;
            mem_wdata <= w_wdata;
            r_cnt     <= '0;
            r_abort   <= 1'b0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (mem_ack) begin
            mem_req <= 1'b0;
            r_rdata <= mem_rdata;
            r_abort <= 1'b0;
          end else if (w_timeout) begin
            mem_req <= 1'b0;
            r_abort <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (alu_out_mem[1:0])
      2'b00:   w_byte = r_rdata[31:24];
      2'b01:   w_byte = r_rdata[23:16];
      2'b10:   w_byte = r_rdata[15:8];
      default: w_byte = r_rdata[7:0];
    endcase
    w_half = alu_out_mem[1] ? r_rdata[15:0] : r_rdata[31:16];
    case (size_mem)
      2'b00:   w_load_data = {{24{se_mem & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{se_mem & w_half[15]}}, w_half};
      default: w_load_data = r_rdata;
    endcase
  end

  // A trap or an aborted access must not write the register file
  assign w_fault = trap_misalign | ((r_state == S_DONE) & r_abort);

  always_ff @(posedge clk) begin
    if (R) begin
      wb_data  <= '0;
      rf_le_wb <= 1'b0;
      rd_wb    <= '0;
    end else if (stall_mem) begin
      rf_le_wb <= 1'b0;
    end else begin
      rd_wb    <= rd_mem;
      rf_le_wb <= rf_le_mem & ~w_fault;
      wb_data  <= load_mem ? w_load_data : alu_out_mem;
    end
  end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Directed bench for mem_stage_access_unit with a write-back scoreboard.
module tb_mem_stage_access_unit;

  logic        clk = 1'b0;
  logic        R;
  logic        load_mem, rf_le_mem, E_mem, rw_dm_mem, se_mem;
  logic [1:0]  size_mem;
  logic [31:0] alu_out_mem, st_data_mem;
  logic [4:0]  rd_mem;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        stall_mem, trap_misalign, bus_err;
  logic [31:0] wb_data;
  logic        rf_le_wb;
  logic [4:0]  rd_wb;

  mem_stage_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .R(R), .load_mem(load_mem), .rf_le_mem(rf_le_mem), .E_mem(E_mem),
    .size_mem(size_mem), .rw_dm_mem(rw_dm_mem), .se_mem(se_mem),
    .alu_out_mem(alu_out_mem), .st_data_mem(st_data_mem), .rd_mem(rd_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_mem(stall_mem), .trap_misalign(trap_misalign), .bus_err(bus_err),
    .wb_data(wb_data), .rf_le_wb(rf_le_wb), .rd_wb(rd_wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        le;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  int stall_n, wait_n, trap_n, err_n, err_at;
  logic        done_req, finished;
  logic        snap_we;
  logic [3:0]  snap_be;
  logic [31:0] snap_addr, snap_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one EX/MEM instruction and runs it until the pipeline advances.
  task automatic access(input string tag, input logic ld, input logic le, input logic en,
                        input logic [1:0] sz, input logic rw, input logic se,
                        input logic [31:0] addr, input logic [31:0] st, input logic [4:0] rd,
                        input int ack_at, input logic [31:0] rdata);
    load_mem = ld; rf_le_mem = le; E_mem = en; size_mem = sz; rw_dm_mem = rw;
    se_mem = se; alu_out_mem = addr; st_data_mem = st; rd_mem = rd; mem_rdata = rdata;
    stall_n = 0; wait_n = 0; trap_n = 0; err_n = 0; err_at = 0;
    done_req = 1'b1; finished = 1'b0;
    snap_we = 1'bx; snap_be = 'x; snap_addr = 'x; snap_wdata = 'x;
    #1;
    for (int c = 0; c < 60; c++) begin
      if (mem_req) begin
        wait_n++;
        if (wait_n == 1) begin
          snap_we = mem_we; snap_be = mem_be; snap_addr = mem_addr; snap_wdata = mem_wdata;
        end
        mem_ack = (wait_n == ack_at);
        #1;
      end
      if (bus_err) begin err_n++; err_at = wait_n; end
      if (trap_misalign) trap_n++;
      if (stall_mem) stall_n++;
      else begin
        done_req = mem_req;
        tick();
        mem_ack = 1'b0;
        finished = 1'b1;
        break;
      end
      tick();
      mem_ack = 1'b0;
    end
    chk({tag, " completes"}, 32'(finished), 32'd1);
    $display("txn %s: addr=0x%08h stall=%0d wait=%0d trap=%0d buserr=%0d wb_le=%0d rd=%0d wb=0x%08h",
             tag, addr, stall_n, wait_n, trap_n, err_n, rf_le_wb, rd_wb, wb_data);
  endtask

  task automatic check_wb(input string tag);
    exp_t e;
    n_assert++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s sb: observed=empty expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, " rf_le_wb"}, 32'(rf_le_wb), 32'(e.le));
    chk({tag, " rd_wb"}, 32'(rd_wb), 32'(e.rd));
    if (e.chk_data) chk({tag, " wb_data"}, wb_data, e.data);
  endtask

  initial begin
    R = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    load_mem = 1'b1; rf_le_mem = 1'b1; E_mem = 1'b1; size_mem = 2'b10; rw_dm_mem = 1'b0;
    se_mem = 1'b0; alu_out_mem = 32'h100; st_data_mem = '0; rd_mem = 5'd1;
    tick(); tick();
    chk("rst mem_req", 32'(mem_req), 0);
    chk("rst stall", 32'(stall_mem), 0);
    chk("rst trap", 32'(trap_misalign), 0);
    chk("rst rf_le_wb", 32'(rf_le_wb), 0);
    chk("rst wb_data", wb_data, 0);
    chk("rst rd_wb", 32'(rd_wb), 0);
    R = 1'b0; E_mem = 1'b0;

    // 1: aligned word load, ack on second WAIT cycle
    sb.push_back('{le: 1'b1, rd: 5'd5, data: 32'hDEADBEEF, chk_data: 1'b1});
    access("word_ld", 1, 1, 1, 2'b10, 0, 0, 32'h100, 0, 5'd5, 2, 32'hDEADBEEF);
    chk("word_ld be", 32'(snap_be), 32'hF);
    chk("word_ld addr", snap_addr, 32'h100);
    chk("word_ld we", 32'(snap_we), 0);
    chk("word_ld stall", stall_n, 3);
    chk("word_ld done req", 32'(done_req), 0);
    check_wb("word_ld");

    // 2: byte loads, signed and unsigned
    sb.push_back('{le: 1'b1, rd: 5'd6, data: 32'hFFFFFFF0, chk_data: 1'b1});
    access("sbyte_ld", 1, 1, 1, 2'b00, 0, 1, 32'h103, 0, 5'd6, 1, 32'h123456F0);
    chk("sbyte_ld be", 32'(snap_be), 32'h1);
    chk("sbyte_ld stall", stall_n, 2);
    check_wb("sbyte_ld");
    sb.push_back('{le: 1'b1, rd: 5'd7, data: 32'h000000F0, chk_data: 1'b1});
    access("ubyte_ld", 1, 1, 1, 2'b00, 0, 0, 32'h103, 0, 5'd7, 1, 32'h123456F0);
    check_wb("ubyte_ld");
    sb.push_back('{le: 1'b1, rd: 5'd11, data: 32'hFFFFFFB4, chk_data: 1'b1});
    access("sbyte1_ld", 1, 1, 1, 2'b00, 0, 1, 32'h101, 0, 5'd11, 3, 32'h12B45678);
    chk("sbyte1_ld be", 32'(snap_be), 32'h4);
    check_wb("sbyte1_ld");
    sb.push_back('{le: 1'b1, rd: 5'd12, data: 32'h0000ABCD, chk_data: 1'b1});
    access("uhalf_ld", 1, 1, 1, 2'b01, 0, 0, 32'h102, 0, 5'd12, 1, 32'h1234ABCD);
    chk("uhalf_ld be", 32'(snap_be), 32'h3);
    check_wb("uhalf_ld");
    sb.push_back('{le: 1'b1, rd: 5'd13, data: 32'hFFFF8001, chk_data: 1'b1});
    access("shalf_ld", 1, 1, 1, 2'b01, 0, 1, 32'h100, 0, 5'd13, 1, 32'h80011234);
    chk("shalf_ld be", 32'(snap_be), 32'hC);
    check_wb("shalf_ld");

    // 3: stores
    sb.push_back('{le: 1'b0, rd: 5'd2, data: 32'h202, chk_data: 1'b1});
    access("half_st", 0, 0, 1, 2'b01, 1, 0, 32'h202, 32'h0000ABCD, 5'd2, 1, 32'h0);
    chk("half_st we", 32'(snap_we), 1);
    chk("half_st be", 32'(snap_be), 32'h3);
    chk("half_st wdata", snap_wdata, 32'hABCDABCD);
    chk("half_st addr", snap_addr, 32'h200);
    check_wb("half_st");
    sb.push_back('{le: 1'b0, rd: 5'd2, data: 32'h201, chk_data: 1'b1});
    access("byte_st", 0, 0, 1, 2'b00, 1, 0, 32'h201, 32'h00000055, 5'd2, 2, 32'h0);
    chk("byte_st be", 32'(snap_be), 32'h4);
    chk("byte_st wdata", snap_wdata, 32'h55555555);
    check_wb("byte_st");

    // Non-memory instruction passes straight through
    sb.push_back('{le: 1'b1, rd: 5'd9, data: 32'h1234, chk_data: 1'b1});
    access("alu_op", 0, 1, 0, 2'b10, 0, 0, 32'h1234, 0, 5'd9, 0, 32'h0);
    chk("alu_op stall", stall_n, 0);
    check_wb("alu_op");

    // 4: misaligned accesses
    sb.push_back('{le: 1'b0, rd: 5'd3, data: 32'h0, chk_data: 1'b0});
    access("mis_word", 1, 1, 1, 2'b10, 0, 0, 32'h101, 0, 5'd3, 1, 32'h0);
    chk("mis_word trap", trap_n, 1);
    chk("mis_word req", wait_n, 0);
    chk("mis_word stall", stall_n, 0);
    check_wb("mis_word");
    sb.push_back('{le: 1'b0, rd: 5'd4, data: 32'h0, chk_data: 1'b0});
    access("mis_half", 1, 1, 1, 2'b01, 0, 0, 32'h103, 0, 5'd4, 1, 32'h0);
    chk("mis_half trap", trap_n, 1);
    check_wb("mis_half");
    sb.push_back('{le: 1'b0, rd: 5'd14, data: 32'h0, chk_data: 1'b0});
    access("mis_sz11", 1, 1, 1, 2'b11, 0, 0, 32'h102, 0, 5'd14, 1, 32'h0);
    chk("mis_sz11 trap", trap_n, 1);
    check_wb("mis_sz11");

    // 5: timeout with no ack
    sb.push_back('{le: 1'b0, rd: 5'd4, data: 32'h0, chk_data: 1'b0});
    access("timeout", 1, 1, 1, 2'b10, 0, 0, 32'h300, 0, 5'd4, 0, 32'h0);
    chk("timeout buserr count", err_n, 1);
    chk("timeout buserr cycle", err_at, 16);
    chk("timeout stall", stall_n, 17);
    chk("timeout done req", 32'(done_req), 0);
    check_wb("timeout");
    sb.push_back('{le: 1'b1, rd: 5'd10, data: 32'h77, chk_data: 1'b1});
    access("post_to_alu", 0, 1, 0, 2'b10, 0, 0, 32'h77, 0, 5'd10, 0, 32'h0);
    chk("post_to_alu stall", stall_n, 0);
    check_wb("post_to_alu");

    // 6: reset during WAIT, then a stray ack
    load_mem = 1; rf_le_mem = 1; E_mem = 1; size_mem = 2'b10; rw_dm_mem = 0;
    alu_out_mem = 32'h400; rd_mem = 5'd15;
    #1;
    chk("rstw stall idle", 32'(stall_mem), 1);
    tick();
    chk("rstw req in wait", 32'(mem_req), 1);
    R = 1'b1;
    tick();
    chk("rstw mem_req", 32'(mem_req), 0);
    chk("rstw mem_addr", mem_addr, 0);
    chk("rstw mem_be", 32'(mem_be), 0);
    chk("rstw mem_we", 32'(mem_we), 0);
    chk("rstw mem_wdata", mem_wdata, 0);
    chk("rstw wb_data", wb_data, 0);
    chk("rstw rd_wb", 32'(rd_wb), 0);
    chk("rstw rf_le_wb", 32'(rf_le_wb), 0);
    chk("rstw stall", 32'(stall_mem), 0);
    R = 1'b0; E_mem = 1'b0; rf_le_mem = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    #1;
    chk("rstw ack stall", 32'(stall_mem), 0);
    tick();
    mem_ack = 1'b0;
    chk("rstw ack req", 32'(mem_req), 0);
    chk("rstw ack rf_le", 32'(rf_le_wb), 0);
    sb.push_back('{le: 1'b1, rd: 5'd8, data: 32'hCAFEF00D, chk_data: 1'b1});
    access("post_rst_ld", 1, 1, 1, 2'b10, 0, 0, 32'h500, 0, 5'd8, 1, 32'hCAFEF00D);
    chk("post_rst_ld addr", snap_addr, 32'h500);
    chk("post_rst_ld stall", stall_n, 2);
    check_wb("post_rst_ld");
    E_mem = 1'b0;

    chk("sb drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
